// File: rtl/riscv_dmem_arbiter.sv
// riscv_dmem_arbiter
// Shares the single-port data memory between the MEM stage and a DMA/debug
// port. The core has priority and sees combinational read data in the same
// cycle. A starvation counter forces a one-shot DMA grant after STARVE_MAX
// blocked cycles. DMA read data comes back registered one cycle after accept.

`ifndef XLEN
`define XLEN 32
`endif

module riscv_dmem_arbiter #(
  parameter int STARVE_MAX = 8,
  parameter int CNT_W      = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_core_req,
  input  logic [`XLEN-1:0]  i_core_addr,
  input  logic [`XLEN-1:0]  i_core_wdata,
  input  logic              i_core_we,
  input  logic [3:0]        i_core_byte_sel,
  input  logic              i_core_unsigned,
  output logic [`XLEN-1:0]  o_core_rdata,
  output logic              o_core_stall,
  input  logic              i_dma_valid,
  output logic              o_dma_ready,
  input  logic [`XLEN-1:0]  i_dma_addr,
  input  logic [`XLEN-1:0]  i_dma_wdata,
  input  logic              i_dma_we,
  input  logic [3:0]        i_dma_byte_sel,
  output logic              o_dma_rvalid,
  output logic [`XLEN-1:0]  o_dma_rdata,
  output logic [`XLEN-1:0]  o_mem_addr,
  output logic [`XLEN-1:0]  o_mem_wdata,
  output logic              o_mem_we,
  output logic [3:0]        o_mem_byte_sel,
  output logic              o_mem_unsigned,
  input  logic [`XLEN-1:0]  i_mem_rdata
);

  logic [CNT_W-1:0]  starve_cnt_r;
  logic              dma_rvalid_r;
  logic [`XLEN-1:0]  dma_rdata_r;

  logic              force_s;
  logic              dma_ready_s;
  logic              gnt_dma_s;
  logic              gnt_core_s;

  // Arbitration: core wins unless the DMA has been starved long enough.
  always_comb begin
    force_s     = (starve_cnt_r == CNT_W'(STARVE_MAX));
    dma_ready_s = ~i_core_req | force_s;
    gnt_dma_s   = i_dma_valid & dma_ready_s;
    gnt_core_s  = i_core_req & ~gnt_dma_s;
  end

  // Memory port mux; the core owns the address bus whenever the DMA is not granted.
  always_comb begin
    o_dma_ready  = dma_ready_s;
    o_core_stall = i_core_req & gnt_dma_s;
    o_core_rdata = i_mem_rdata;
    o_mem_we     = (gnt_core_s & i_core_we) | (gnt_dma_s & i_dma_we);
    if (gnt_dma_s) begin
      o_mem_addr     = i_dma_addr;
      o_mem_wdata    = i_dma_wdata;
      o_mem_byte_sel = i_dma_byte_sel;
      o_mem_unsigned = 1'b1;
    end else begin
      o_mem_addr     = i_core_addr;
      o_mem_wdata    = i_core_wdata;
      o_mem_byte_sel = i_core_byte_sel;
      o_mem_unsigned = i_core_unsigned;
    end
  end

  // Starvation counter: counts blocked DMA cycles, clears on accept or when valid drops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (gnt_dma_s || !i_dma_valid) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (!force_s) begin
      starve_cnt_r <= starve_cnt_r + CNT_W'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // DMA read response: capture memory data the edge after a read is accepted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dma_rvalid_r <= 1'b0;
      dma_rdata_r  <= {`XLEN{1'b0}};
    end else if (gnt_dma_s && !i_dma_we) begin
      dma_rvalid_r <= 1'b1;
      dma_rdata_r  <= i_mem_rdata;
    end else begin
      dma_rvalid_r <= 1'b0;
      dma_rdata_r  <= dma_rdata_r;
    end
  end

  assign o_dma_rvalid = dma_rvalid_r;
  assign o_dma_rdata  = dma_rdata_r;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Testbench for riscv_dmem_arbiter: directed scenarios plus randomized
// traffic, checked through a scoreboard against a byte-level memory model.

module tb_riscv_dmem_arbiter;

  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req = 1'b0, core_we = 1'b0, core_unsigned = 1'b0;
  logic [31:0] core_addr = 32'h0, core_wdata = 32'h0;
  logic [3:0]  core_byte_sel = 4'h0;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        dma_valid = 1'b0, dma_we = 1'b0;
  logic        dma_ready, dma_rvalid;
  logic [31:0] dma_addr = 32'h0, dma_wdata = 32'h0, dma_rdata;
  logic [3:0]  dma_byte_sel = 4'h0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_unsigned;
  logic [3:0]  mem_byte_sel;

  int checks = 0;
  int errors = 0;

  riscv_dmem_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_core_req(core_req), .i_core_addr(core_addr), .i_core_wdata(core_wdata),
    .i_core_we(core_we), .i_core_byte_sel(core_byte_sel), .i_core_unsigned(core_unsigned),
    .o_core_rdata(core_rdata), .o_core_stall(core_stall),
    .i_dma_valid(dma_valid), .o_dma_ready(dma_ready), .i_dma_addr(dma_addr),
    .i_dma_wdata(dma_wdata), .i_dma_we(dma_we), .i_dma_byte_sel(dma_byte_sel),
    .o_dma_rvalid(dma_rvalid), .o_dma_rdata(dma_rdata),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
    .o_mem_byte_sel(mem_byte_sel), .o_mem_unsigned(mem_unsigned), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- environment data memory (word organised) ----------------
  logic [31:0] env_mem [0:63];
  logic [31:0] env_word;
  initial for (int i = 0; i < 64; i++) env_mem[i] = 32'h0;

  // Combinational read: shift the addressed lane down, then size/extend.
  always_comb begin
    env_word = env_mem[mem_addr[7:2]] >> {mem_addr[1:0], 3'b000};
    case (mem_byte_sel)
      4'b0001: mem_rdata = mem_unsigned ? {24'h0, env_word[7:0]}  : {{24{env_word[7]}}, env_word[7:0]};
      4'b0011: mem_rdata = mem_unsigned ? {16'h0, env_word[15:0]} : {{16{env_word[15]}}, env_word[15:0]};
      default: mem_rdata = env_word;
    endcase
  end

  // Write: byte lanes and data shifted up to the byte offset.
  always @(posedge clk) begin
    logic [7:0]  sel_sh;
    logic [63:0] wd_sh;
    sel_sh = {4'h0, mem_byte_sel} << mem_addr[1:0];
    wd_sh  = {32'h0, mem_wdata} << {mem_addr[1:0], 3'b000};
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (sel_sh[i]) env_mem[mem_addr[7:2]][8*i +: 8] <= wd_sh[8*i +: 8];
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [0:255];
  initial for (int i = 0; i < 256; i++) ref_mem[i] = 8'h0;
  int   blocked = 0;          // consecutive cycles DMA was valid but refused
  bit   prev_dma_read = 0;    // a DMA read was accepted last cycle
  bit   last_dma_go = 0;

  typedef struct { bit ready; bit stall; bit we; bit rvalid; } ctrl_t;
  ctrl_t       ctrl_q[$];
  logic [31:0] core_q[$];
  logic [31:0] dma_q[$];

  function automatic int size_of(input logic [3:0] sel);
    return (sel == 4'b0001) ? 1 : (sel == 4'b0011) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [3:0] sel, input bit uns);
    int n = size_of(sel);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(a + i) & 255];
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
    return v;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [3:0] sel, input logic [31:0] d);
    int n = size_of(sel);
    for (int i = 0; i < n; i++) ref_mem[(a + i) & 255] = d[8*i +: 8];
  endtask

  // Drive one cycle of stimulus and record what the arbiter should do with it.
  task automatic drive(input bit creq, input bit cwe, input logic [31:0] caddr,
                       input logic [31:0] cwd, input logic [3:0] csel, input bit cuns,
                       input bit dval, input bit dwe, input logic [31:0] daddr,
                       input logic [31:0] dwd, input logic [3:0] dsel);
    ctrl_t c;
    bit dma_go, core_go;
    @(posedge clk); #1;
    core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd;
    core_byte_sel = csel; core_unsigned = cuns;
    dma_valid = dval; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd; dma_byte_sel = dsel;

    c.ready = !creq || (blocked == STARVE_MAX);
    dma_go  = dval && c.ready;
    core_go = creq && !dma_go;
    c.stall  = creq && dma_go;
    c.we     = (core_go && cwe) || (dma_go && dwe);
    c.rvalid = prev_dma_read;
    ctrl_q.push_back(c);

    if (core_go && !cwe) core_q.push_back(ref_read(caddr, csel, cuns));
    if (dma_go && !dwe)  dma_q.push_back(ref_read(daddr, dsel, 1'b1));
    if (core_go && cwe)  ref_write(caddr, csel, cwd);
    if (dma_go && dwe)   ref_write(daddr, dsel, dwd);

    blocked       = (!dval || dma_go) ? 0 : blocked + 1;
    prev_dma_read = dma_go && !dwe;
    last_dma_go   = dma_go;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 32'h0, 4'hF, 0, 0, 0, 32'h0, 32'h0, 4'hF);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    ctrl_t c;
    if (ctrl_q.size() > 0) begin
      c = ctrl_q.pop_front();
      chk("dma_ready",  {31'h0, dma_ready},  {31'h0, c.ready});
      chk("core_stall", {31'h0, core_stall}, {31'h0, c.stall});
      chk("mem_we",     {31'h0, mem_we},     {31'h0, c.we});
      chk("dma_rvalid", {31'h0, dma_rvalid}, {31'h0, c.rvalid});
    end
    if (!rst && core_req && !core_stall && !core_we) begin
      if (core_q.size() == 0) chk("core_read_unexpected", 32'h1, 32'h0);
      else chk("core_rdata", core_rdata, core_q.pop_front());
    end
    if (dma_rvalid) begin
      if (dma_q.size() == 0) chk("dma_rvalid_unexpected", 32'h1, 32'h0);
      else chk("dma_rdata", dma_rdata, dma_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Random naturally aligned access: returns byte select and address.
  task automatic rand_access(output logic [3:0] sel, output logic [31:0] addr);
    int k = $urandom_range(0, 2);
    logic [31:0] w = $urandom_range(0, 63);
    sel  = (k == 0) ? 4'b0001 : (k == 1) ? 4'b0011 : 4'b1111;
    addr = (w << 2) | ((k == 0) ? 32'($urandom_range(0, 3)) : (k == 1) ? 32'($urandom_range(0, 1)) * 2 : 32'h0);
  endtask

  initial begin
    bit          dv, dw, cr, cw, cu;
    logic [31:0] da, dd, ca, cd;
    logic [3:0]  ds, cs;

    // Reset state
    #12;
    chk("reset_rvalid", {31'h0, dma_rvalid}, 32'h0);
    chk("reset_rdata",  dma_rdata, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Core store then same-cycle load
    drive(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h0, 32'h0, 4'hF);
    drive(1, 0, 32'h10, 32'h0, 4'hF, 0, 0, 0, 32'h0, 32'h0, 4'hF);
    // DMA read, one-cycle response pulse
    drive(0, 0, 32'h0, 32'h0, 4'hF, 0, 1, 0, 32'h10, 32'h0, 4'hF);
    idle(); idle();
    // DMA halfword write, core lbu of the upper lane
    drive(0, 0, 32'h0, 32'h0, 4'hF, 0, 1, 1, 32'h20, 32'h12345678, 4'b0011);
    drive(1, 0, 32'h21, 32'h0, 4'b0001, 1, 0, 0, 32'h0, 32'h0, 4'hF);

    // Async reset between a DMA read accept and its response edge
    drive(0, 0, 32'h0, 32'h0, 4'hF, 0, 1, 0, 32'h10, 32'h0, 4'hF);
    @(negedge clk); #1;
    rst = 1'b1;
    core_req = 1'b0; dma_valid = 1'b0;
    #1;
    chk("rst_rvalid", {31'h0, dma_rvalid}, 32'h0);
    chk("rst_rdata",  dma_rdata, 32'h0);
    void'(dma_q.pop_back());
    prev_dma_read = 0; blocked = 0;
    @(posedge clk); #1;
    chk("rst_rvalid_after_edge", {31'h0, dma_rvalid}, 32'h0);
    chk("rst_rdata_after_edge",  dma_rdata, 32'h0);
    @(negedge clk); #1 rst = 1'b0;

    // Contention: core stores held, DMA read forced through after 8 blocked cycles
    for (int i = 0; i < 9; i++)
      drive(1, 1, 32'h30, 32'hA5A50000 + i, 4'hF, 0, 1, 0, 32'h10, 32'h0, 4'hF);
    drive(1, 1, 32'h30, 32'h0BADF00D, 4'hF, 0, 0, 0, 32'h0, 32'h0, 4'hF);

    // Contention with valid dropped at cycle 5: counter restarts
    for (int i = 0; i < 4; i++)
      drive(1, 0, 32'h30, 32'h0, 4'hF, 0, 1, 0, 32'h20, 32'h0, 4'hF);
    drive(1, 0, 32'h30, 32'h0, 4'hF, 0, 0, 0, 32'h0, 32'h0, 4'hF);
    for (int i = 0; i < 9; i++)
      drive(1, 0, 32'h30, 32'h0, 4'hF, 0, 1, 0, 32'h20, 32'h0, 4'hF);
    idle();

    // Randomized traffic; DMA holds its request while refused
    dv = 0; dw = 0; da = 0; dd = 0; ds = 4'hF;
    for (int n = 0; n < 1500; n++) begin
      if (dv && !last_dma_go) begin
        if ($urandom_range(0, 7) == 0) dv = 0;
      end else begin
        dv = ($urandom_range(0, 2) != 0);
        dw = $urandom_range(0, 1);
        dd = $urandom;
        rand_access(ds, da);
      end
      cr = ($urandom_range(0, 9) < 7);
      cw = $urandom_range(0, 1);
      cu = $urandom_range(0, 1);
      cd = $urandom;
      rand_access(cs, ca);
      drive(cr, cw, ca, cd, cs, cu, dv, dw, da, dd, ds);
    end
    idle(); idle();
    @(negedge clk); @(negedge clk);

    chk("ctrl_q_drained", ctrl_q.size(), 32'h0);
    chk("core_q_drained", core_q.size(), 32'h0);
    chk("dma_q_drained",  dma_q.size(),  32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
